// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmit FSM states and divisor helpers.
package uart_pkg;

   localparam int DIV_W = 16;

   // Register select values as seen on address[3:2]
   localparam logic [1:0] REG_TXDATA   = 2'd0;
   localparam logic [1:0] REG_STATUS   = 2'd1;
   localparam logic [1:0] REG_BAUD_DIV = 2'd2;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_IDLE  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // A zero divisor would stall the baud counter, so it is promoted to 1
   function automatic logic [DIV_W-1:0] sanitize_div(input logic [DIV_W-1:0] d);
      if (d == {DIV_W{1'b0}}) begin
         return {{(DIV_W-1){1'b0}}, 1'b1};
      end else begin
         return d;
      end
   endfunction

endpackage

// File: rtl/uart_tx_controller_fifo.sv
// Synchronous first-word-fall-through FIFO holding bytes awaiting transmission.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             push_s;
   logic             pop_s;

   assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty  = (wr_ptr_r == rd_ptr_r);
   assign push_s = push & ~full;
   assign pop_s  = pop & ~empty;
   assign dout   = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer update; wraps modulo 2*DEPTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/uart_tx_controller.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter
// and frame FSM. The line output is registered so reset drives it high at once.
module uart_tx_controller
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH       = 8,
   parameter int DEFAULT_BAUD_DIV = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [3:0]  byte_enable,
   input  logic        write_enable,
   input  logic        enable,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        tx
);

   localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_BAUD_DIV);
   localparam logic [DIV_W-1:0] ONE_DIV = {{(DIV_W-1){1'b0}}, 1'b1};

   tx_state_e        state_r, state_nx_s;
   logic [2:0]       bit_cnt_r, bit_cnt_nx_s;
   logic [DIV_W-1:0] baud_cnt_r, baud_cnt_nx_s;
   logic [DIV_W-1:0] div_lat_r, div_lat_nx_s;
   logic [DIV_W-1:0] baud_div_r;
   logic [DIV_W-1:0] baud_wr_val_s;
   logic [7:0]       shift_r, shift_nx_s;
   logic             tx_r;
   logic             line_s;

   logic [1:0]       reg_sel_s;
   logic             wr_access_s;
   logic             txdata_wr_s;
   logic             baud_wr_s;
   logic             ready_s;
   logic             push_s;
   logic             pop_s;
   logic             tick_s;
   logic [7:0]       fifo_dout_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [3:0]       status_s;
   logic             unused_s;

   assign reg_sel_s   = address[3:2];
   assign wr_access_s = enable & write_enable;
   assign txdata_wr_s = wr_access_s & (reg_sel_s == REG_TXDATA);
   assign baud_wr_s   = wr_access_s & (reg_sel_s == REG_BAUD_DIV) & (|byte_enable[1:0]);
   assign ready_s     = ~(txdata_wr_s & fifo_full_s);
   assign push_s      = txdata_wr_s & ready_s & byte_enable[0];
   assign ready       = ready_s;
   assign tx          = tx_r;
   assign tick_s      = (baud_cnt_r == {DIV_W{1'b0}});
   assign unused_s    = ^{address[31:4], address[1:0], write_data[31:16], byte_enable[3:2]};

   assign baud_wr_val_s = {byte_enable[1] ? write_data[15:8] : baud_div_r[15:8],
                           byte_enable[0] ? write_data[7:0]  : baud_div_r[7:0]};

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push_s),
      .pop  (pop_s),
      .din  (write_data[7:0]),
      .dout (fifo_dout_s),
      .full (fifo_full_s),
      .empty(fifo_empty_s)
   );

   // STATUS assembly and read mux
   always_comb begin
      status_s             = 4'd0;
      status_s[STAT_BUSY]  = (state_r != IDLE);
      status_s[STAT_FULL]  = fifo_full_s;
      status_s[STAT_EMPTY] = fifo_empty_s;
      status_s[STAT_IDLE]  = fifo_empty_s & (state_r == IDLE);
      read_data            = 32'd0;
      case (reg_sel_s)
         REG_STATUS:   read_data = {28'd0, status_s};
         REG_BAUD_DIV: read_data = {16'd0, baud_div_r};
         default:      read_data = 32'd0;
      endcase
   end

   // Divisor register, byte-lane writable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_div_r <= RST_DIV;
      end else if (baud_wr_s) begin
         baud_div_r <= sanitize_div(baud_wr_val_s);
      end
   end

   // Frame FSM next state; a pop loads the shifter and latches the divisor
   always_comb begin
      state_nx_s    = state_r;
      bit_cnt_nx_s  = bit_cnt_r;
      baud_cnt_nx_s = baud_cnt_r;
      div_lat_nx_s  = div_lat_r;
      shift_nx_s    = shift_r;
      pop_s         = 1'b0;
      line_s        = 1'b1;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s) begin
               pop_s         = 1'b1;
               shift_nx_s    = fifo_dout_s;
               div_lat_nx_s  = baud_div_r;
               baud_cnt_nx_s = baud_div_r - ONE_DIV;
               state_nx_s    = START;
            end else begin
               state_nx_s    = IDLE;
            end
         end
         START: begin
            line_s = 1'b0;
            if (tick_s) begin
               baud_cnt_nx_s = div_lat_r - ONE_DIV;
               bit_cnt_nx_s  = 3'd0;
               state_nx_s    = DATA;
            end else begin
               baud_cnt_nx_s = baud_cnt_r - ONE_DIV;
            end
         end
         DATA: begin
            line_s = shift_r[0];
            if (tick_s) begin
               baud_cnt_nx_s = div_lat_r - ONE_DIV;
               shift_nx_s    = {1'b0, shift_r[7:1]};
               if (bit_cnt_r == 3'd7) begin
                  state_nx_s = STOP;
               end else begin
                  bit_cnt_nx_s = bit_cnt_r + 3'd1;
               end
            end else begin
               baud_cnt_nx_s = baud_cnt_r - ONE_DIV;
            end
         end
         STOP: begin
            line_s = 1'b1;
            if (tick_s) begin
               if (!fifo_empty_s) begin
                  pop_s         = 1'b1;
                  shift_nx_s    = fifo_dout_s;
                  div_lat_nx_s  = baud_div_r;
                  baud_cnt_nx_s = baud_div_r - ONE_DIV;
                  state_nx_s    = START;
               end else begin
                  state_nx_s    = IDLE;
               end
            end else begin
               baud_cnt_nx_s = baud_cnt_r - ONE_DIV;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // FSM, counters and registered line output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         bit_cnt_r  <= 3'd0;
         baud_cnt_r <= {DIV_W{1'b0}};
         div_lat_r  <= RST_DIV;
         shift_r    <= 8'd0;
         tx_r       <= 1'b1;
      end else begin
         state_r    <= state_nx_s;
         bit_cnt_r  <= bit_cnt_nx_s;
         baud_cnt_r <= baud_cnt_nx_s;
         div_lat_r  <= div_lat_nx_s;
         shift_r    <= shift_nx_s;
         tx_r       <= line_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed self-checking bench for uart_tx_controller: register access, frame
// timing, FIFO back-pressure, divisor changes and asynchronous reset.
module tb_uart_tx_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] address = 32'd0;
   logic [31:0] write_data = 32'd0;
   logic [3:0]  byte_enable = 4'd0;
   logic        write_enable = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] read_data;
   logic        ready;
   logic        tx;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic        tx_log [8192];
   logic [7:0]  exp_byte [16];
   int          exp_div [16];
   int          acc_cyc;
   logic        ready_seen;
   int          stall_cycles;
   logic [31:0] rd;
   int          acc [10];
   logic        rdy [10];
   logic [7:0]  burst [10];
   int          e;
   int          ones;

   uart_tx_controller #(
      .FIFO_DEPTH(8),
      .DEFAULT_BAUD_DIV(868)
   ) dut (
      .clk(clk),
      .rst(rst),
      .address(address),
      .write_data(write_data),
      .byte_enable(byte_enable),
      .write_enable(write_enable),
      .enable(enable),
      .read_data(read_data),
      .ready(ready),
      .tx(tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (cyc < 8192) tx_log[cyc] <= tx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      else if (i == 9) return 1'b1;
      else return b[i-1];
   endfunction

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      @(negedge clk);
      address = addr; write_data = data; byte_enable = be;
      write_enable = 1'b1; enable = 1'b1;
      #1;
      ready_seen = ready;
      stall_cycles = 0;
      while (ready !== 1'b1 && stall_cycles < 200) begin
         @(negedge clk); #1;
         stall_cycles++;
      end
      if (stall_cycles >= 200) check("write_timeout", stall_cycles, 0);
      @(posedge clk); #1;
      acc_cyc = cyc;
      enable = 1'b0; write_enable = 1'b0; byte_enable = 4'd0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      address = addr; write_enable = 1'b0; enable = 1'b1;
      #1;
      data = read_data;
      @(posedge clk); #1;
      enable = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
      @(negedge clk);
   endtask

   // Compares logged line against expected frames starting at cycle 'start'
   task automatic check_frames(input string tag, input int start, input int n);
      int t;
      int bad;
      t = start;
      check({tag, "_before"}, tx_log[start-1], 1'b1);
      for (int f = 0; f < n; f++) begin
         bad = 0;
         for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < exp_div[f]; k++) begin
               if (tx_log[t] !== frame_bit(exp_byte[f], b)) bad++;
               t++;
            end
         end
         check($sformatf("%s_frame%0d_bad_cycles", tag, f), bad, 0);
      end
      check({tag, "_after"}, tx_log[t], 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("tx_in_reset", tx, 1'b1);
      rst = 1'b0;
      bus_read(32'h4, rd);
      check("status_after_reset", rd, 32'h0000_000C);
      check("tx_after_reset", tx, 1'b1);
      check("ready_after_reset", ready, 1'b1);
      bus_read(32'h8, rd);
      check("baud_reset", rd, 32'd868);

      // Single frame 0xA5 at div 4
      bus_write(32'h8, 32'd4, 4'b0011);
      bus_read(32'h8, rd);
      check("baud_div4", rd, 32'd4);
      bus_write(32'h0, 32'h0000_00A5, 4'b0001);
      e = acc_cyc;
      bus_read(32'h4, rd);
      check("status_after_push", rd, 32'h0000_0000);
      bus_read(32'h4, rd);
      check("status_busy", rd, 32'h0000_0005);
      exp_byte[0] = 8'hA5; exp_div[0] = 4;
      wait_until(e + 2 + 40 + 2);
      check_frames("a5", e + 2, 1);
      bus_read(32'h4, rd);
      check("status_done_a5", rd, 32'h0000_000C);

      // Ten back-to-back writes at div 2; tenth stalls until the second pop
      bus_write(32'h8, 32'd2, 4'b0011);
      burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h3C; burst[3] = 8'h81; burst[4] = 8'h5A;
      burst[5] = 8'h01; burst[6] = 8'h80; burst[7] = 8'hC3; burst[8] = 8'h7E; burst[9] = 8'h96;
      for (int i = 0; i < 10; i++) begin
         bus_write(32'h0, {24'd0, burst[i]}, 4'b0001);
         acc[i] = acc_cyc;
         rdy[i] = ready_seen;
         exp_byte[i] = burst[i];
         exp_div[i] = 2;
      end
      check("burst_ready_9th", rdy[8], 1'b1);
      check("burst_ready_10th", rdy[9], 1'b0);
      check("burst_acc_9th", acc[8] - acc[0], 8);
      check("burst_acc_10th", acc[9] - acc[0], 22);
      wait_until(acc[0] + 2 + 200 + 2);
      check_frames("burst", acc[0] + 2, 10);
      bus_read(32'h4, rd);
      check("status_done_burst", rd, 32'h0000_000C);

      // Divisor change mid-frame only affects the next frame
      bus_write(32'h8, 32'd4, 4'b0011);
      bus_write(32'h0, 32'h0000_003C, 4'b0001);
      e = acc_cyc;
      bus_write(32'h0, 32'h0000_00C5, 4'b0001);
      wait_until(e + 10);
      bus_write(32'h8, 32'd8, 4'b0011);
      exp_byte[0] = 8'h3C; exp_div[0] = 4;
      exp_byte[1] = 8'hC5; exp_div[1] = 8;
      wait_until(e + 2 + 120 + 2);
      check_frames("divchg", e + 2, 2);
      bus_write(32'h8, 32'd0, 4'b0011);
      bus_read(32'h8, rd);
      check("baud_zero_reads_one", rd, 32'd1);
      bus_write(32'h8, 32'h0000_AB00, 4'b0010);
      bus_read(32'h8, rd);
      check("baud_high_lane", rd, 32'h0000_AB01);

      // Reset mid-frame with bytes queued
      bus_write(32'h8, 32'd4, 4'b0011);
      bus_write(32'h0, 32'h0000_0000, 4'b0001);
      e = acc_cyc;
      bus_write(32'h0, 32'h0000_0011, 4'b0001);
      bus_write(32'h0, 32'h0000_0022, 4'b0001);
      bus_write(32'h0, 32'h0000_0033, 4'b0001);
      wait_until(e + 12);
      check("tx_data_before_reset", tx, 1'b0);
      rst = 1'b1;
      #1;
      check("tx_reset_async", tx, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus_read(32'h4, rd);
      check("status_after_midreset", rd, 32'h0000_000C);
      bus_read(32'h8, rd);
      check("baud_after_midreset", rd, 32'd868);
      e = cyc;
      wait_until(e + 200);
      ones = 0;
      for (int i = 0; i < 200; i++) if (tx_log[e + i] === 1'b1) ones++;
      check("no_frames_after_reset", ones, 200);

      // Writes that must not push
      bus_write(32'h0, 32'h0000_0055, 4'b0010);
      check("ready_txdata_lane1", ready_seen, 1'b1);
      bus_write(32'hC, 32'hFFFF_FFFF, 4'b1111);
      check("ready_reserved", ready_seen, 1'b1);
      bus_read(32'h4, rd);
      check("status_after_ignored", rd, 32'h0000_000C);
      bus_read(32'hC, rd);
      check("reserved_reads_zero", rd, 32'd0);
      bus_read(32'h0, rd);
      check("txdata_reads_zero", rd, 32'd0);
      e = cyc;
      wait_until(e + 20);
      ones = 0;
      for (int i = 0; i < 20; i++) if (tx_log[e + i] === 1'b1) ones++;
      check("line_idle_after_ignored", ones, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
